fifo_port_out_mc: RTL and testbench

- Multi-channel, parametrised successor to the single-channel 32-bit fifo output port.
- Drains NCH agent-side show-ahead output FIFOs into one downstream outfifo through a round-robin arbiter.
- Optional packet-atomic mode keeps a channel's beats contiguous until end-of-packet.
- Throttles on the downstream full flag and full_count credit. Sits between the agent output FIFOs and the accumulator outfifo interface.

---
 rtl/fifo_port_out_mc_pkg.sv | 21 ++
 rtl/fifo_port_out_mc_rr_arb.sv | 43 ++++
 rtl/fifo_port_out_mc.sv | 135 +++++++++++++
 tb/tb_fifo_port_out_mc.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_port_out_mc_pkg.sv
// Shared defaults, lock state encoding and width helper for the multi-channel output port.
package fifo_port_out_mc_pkg;

  localparam int unsigned DEF_NCH       = 4;
  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_TW        = 16;
  localparam int unsigned DEF_OUT_DEPTH = 16;
  localparam int unsigned DEF_CW        = 5;

  // Packet lock state: UNLOCK arbitrates freely, LOCK pins the grant to one channel.
  typedef enum logic {
    UNLOCK = 1'b0,
    LOCK   = 1'b1
  } lock_state_e;

  // Channel-id width; never below one bit so single-channel builds stay legal.
  function automatic int unsigned chw_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_port_out_mc_rr_arb.sv
// Round-robin arbiter with optional lock onto a single channel; purely combinational.
module fifo_port_rr_arb
  import fifo_port_out_mc_pkg::*;
#(
  parameter  int unsigned NCH = DEF_NCH,
  localparam int unsigned CHW = chw_of(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  input  logic           lock_en,
  input  logic [CHW-1:0] lock_ch,
  output logic [NCH-1:0] gnt_c,
  output logic [CHW-1:0] gnt_idx_c,
  output logic           gnt_vld_c
);

  // Search ptr+1, ptr+2, ... mod NCH for the first requester, or only the lock channel when locked.
  always_comb begin
    int unsigned idx;
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    idx       = 0;
    if (lock_en) begin
      if (req[lock_ch]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = lock_ch;
      end
    end else begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = (32'(ptr) + k) % NCH;
        if (!gnt_vld_c && req[CHW'(idx)]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = CHW'(idx);
        end
      end
    end
    if (gnt_vld_c) begin
      gnt_c = NCH'(1) << gnt_idx_c;
    end
  end

endmodule

// File: rtl/fifo_port_out_mc.sv
// Multi-channel output port: drains NCH show-ahead agent FIFOs into one downstream outfifo.
module fifo_port_out_mc
  import fifo_port_out_mc_pkg::*;
#(
  parameter  int unsigned NCH       = DEF_NCH,
  parameter  int unsigned DW        = DEF_DW,
  parameter  int unsigned TW        = DEF_TW,
  parameter  int unsigned OUT_DEPTH = DEF_OUT_DEPTH,
  parameter  int unsigned CW        = DEF_CW,
  parameter  int unsigned PKT_MODE  = 1,
  localparam int unsigned CHW       = chw_of(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NCH*DW-1:0] fpo_data_from_agents,
  input  logic [NCH*TW-1:0] fpo_ptag_from_agents,
  input  logic [NCH-1:0]    fpo_eop_from_agents,
  input  logic [NCH-1:0]    fpo_empty_from_agents,
  output logic [NCH-1:0]    acc_rd_from_agents,
  input  logic              fp_outfifo_full,
  input  logic [CW-1:0]     fp_outfifo_full_count,
  output logic [DW-1:0]     fp_outfifo_data,
  output logic [TW-1:0]     fp_outfifo_pkt_tag,
  output logic              fp_outfifo_eop,
  output logic [CHW-1:0]    fp_outfifo_chan,
  output logic              fp_outfifo_write,
  output logic              arb_locked
);

  localparam int unsigned SW = CW + 1;

  lock_state_e    state_q, state_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CHW-1:0] lock_ch_q, lock_ch_d;
  logic           locked_q;

  logic [NCH-1:0] req_c, gnt_c;
  logic [CHW-1:0] gnt_idx_c;
  logic           gnt_vld_c, lock_en_c, credit_ok_c, pop_c;
  logic [SW-1:0]  occ_sum_c;
  logic [DW-1:0]  head_data_c;
  logic [TW-1:0]  head_tag_c;
  logic           head_eop_c;

  assign req_c     = ~fpo_empty_from_agents;
  assign lock_en_c = (PKT_MODE != 0) && (state_q == LOCK);

  // Occupancy plus the beat about to land, widened so OUT_DEPTH itself never wraps.
  assign occ_sum_c   = {1'b0, fp_outfifo_full_count} + SW'(fp_outfifo_write);
  assign credit_ok_c = !fp_outfifo_full && (occ_sum_c < SW'(OUT_DEPTH));

  fifo_port_rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .req       (req_c),
    .ptr       (ptr_q),
    .lock_en   (lock_en_c),
    .lock_ch   (lock_ch_q),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

  // A pop is issued only with credit, an eligible channel, and never while reset is held.
  assign pop_c              = credit_ok_c && gnt_vld_c && !reset;
  assign acc_rd_from_agents = pop_c ? gnt_c : '0;

  // Head-of-line fields of the granted channel.
  always_comb begin
    head_data_c = fpo_data_from_agents[32'(gnt_idx_c) * DW +: DW];
    head_tag_c  = fpo_ptag_from_agents[32'(gnt_idx_c) * TW +: TW];
    head_eop_c  = fpo_eop_from_agents[gnt_idx_c];
  end

  // Lock FSM, round-robin pointer and lock channel registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= UNLOCK;
      ptr_q     <= CHW'(NCH - 1);
      lock_ch_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_ch_q <= lock_ch_d;
      locked_q  <= (state_d == LOCK);
    end
  end

  // Next-state: pointer follows every issued pop; lock opens on a non-eop beat, closes on eop.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_ch_d = lock_ch_q;
    if (pop_c) begin
      ptr_d = gnt_idx_c;
      case (state_q)
        UNLOCK: begin
          if ((PKT_MODE != 0) && !head_eop_c) begin
            state_d   = LOCK;
            lock_ch_d = gnt_idx_c;
          end
        end
        LOCK: begin
          if (head_eop_c) begin
            state_d = UNLOCK;
          end
        end
        default: state_d = UNLOCK;
      endcase
    end
  end

  // Output register: the popped beat is written exactly one cycle after its pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      fp_outfifo_write   <= 1'b0;
      fp_outfifo_data    <= '0;
      fp_outfifo_pkt_tag <= '0;
      fp_outfifo_eop     <= 1'b0;
      fp_outfifo_chan    <= '0;
    end else begin
      fp_outfifo_write <= pop_c;
      if (pop_c) begin
        fp_outfifo_data    <= head_data_c;
        fp_outfifo_pkt_tag <= head_tag_c;
        fp_outfifo_eop     <= head_eop_c;
        fp_outfifo_chan    <= gnt_idx_c;
      end
    end
  end

  assign arb_locked = locked_q;

endmodule

// File: tb/tb_fifo_port_out_mc.sv
// Bench for fifo_port_out_mc: agent FIFO models, downstream occupancy model and a write scoreboard.
module tb_fifo_port_out_mc;

  typedef struct packed {
    logic [63:0] d;
    logic [15:0] t;
    logic        e;
    logic [3:0]  ch;
  } beat_t;

  typedef struct {
    logic       full;
    logic [4:0] fc;
    logic [3:0] mask;
    logic [3:0] exp_rd;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance A: 4 channels, 32-bit data, packet mode
  logic [127:0] a_data;
  logic [63:0]  a_tag;
  logic [3:0]   a_eop, a_empty, a_rd;
  logic         a_full;
  logic [4:0]   a_fc;
  logic [31:0]  a_wdata;
  logic [15:0]  a_wtag;
  logic         a_weop, a_write, a_locked;
  logic [1:0]   a_wchan;

  // Instance B: 2 channels, 64-bit data, 8-bit tag
  logic [127:0] b_data;
  logic [15:0]  b_tag;
  logic [1:0]   b_eop, b_empty, b_rd;
  logic [63:0]  b_wdata;
  logic [7:0]   b_wtag;
  logic         b_weop, b_write, b_locked;
  logic [0:0]   b_wchan;

  fifo_port_out_mc #(.NCH(4), .DW(32), .TW(16), .OUT_DEPTH(16), .CW(5), .PKT_MODE(1)) u_a (
    .clock(clock), .reset(reset),
    .fpo_data_from_agents(a_data), .fpo_ptag_from_agents(a_tag),
    .fpo_eop_from_agents(a_eop), .fpo_empty_from_agents(a_empty),
    .acc_rd_from_agents(a_rd),
    .fp_outfifo_full(a_full), .fp_outfifo_full_count(a_fc),
    .fp_outfifo_data(a_wdata), .fp_outfifo_pkt_tag(a_wtag), .fp_outfifo_eop(a_weop),
    .fp_outfifo_chan(a_wchan), .fp_outfifo_write(a_write), .arb_locked(a_locked)
  );

  fifo_port_out_mc #(.NCH(2), .DW(64), .TW(8), .OUT_DEPTH(16), .CW(5), .PKT_MODE(1)) u_b (
    .clock(clock), .reset(reset),
    .fpo_data_from_agents(b_data), .fpo_ptag_from_agents(b_tag),
    .fpo_eop_from_agents(b_eop), .fpo_empty_from_agents(b_empty),
    .acc_rd_from_agents(b_rd),
    .fp_outfifo_full(1'b0), .fp_outfifo_full_count(5'd0),
    .fp_outfifo_data(b_wdata), .fp_outfifo_pkt_tag(b_wtag), .fp_outfifo_eop(b_weop),
    .fp_outfifo_chan(b_wchan), .fp_outfifo_write(b_write), .arb_locked(b_locked)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t qa [4][$];
  beat_t qb [2][$];
  beat_t expa[$];
  beat_t expb[$];
  int    pop_ch[$];
  int    pop_cyc[$];
  int    popb_ch[$];
  int    wr_cnt = 0;

  int   occ        = 0;
  logic force_full = 1'b0;
  logic drain_en   = 1'b0;
  logic pend_a     = 1'b0;
  logic pend_b     = 1'b0;

  // Negedge snapshots of instance A
  logic [3:0]  s_rd_a;
  logic        s_wa, s_lock_a;
  logic [31:0] s_wdata_a;
  logic [1:0]  s_wchan_a;
  logic [1:0]  s_rd_b;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Present queue heads and downstream status to both instances
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      a_empty[i] = (qa[i].size() == 0);
      a_eop[i]   = 1'b0;
      if (qa[i].size() > 0) begin
        a_data[i*32 +: 32] = qa[i][0].d[31:0];
        a_tag[i*16 +: 16]  = qa[i][0].t;
        a_eop[i]           = qa[i][0].e;
      end
    end
    a_fc   = 5'(occ);
    a_full = force_full;
    for (int i = 0; i < 2; i++) begin
      b_empty[i] = (qb[i].size() == 0);
      b_eop[i]   = 1'b0;
      if (qb[i].size() > 0) begin
        b_data[i*64 +: 64] = qb[i][0].d;
        b_tag[i*8 +: 8]    = qb[i][0].t[7:0];
        b_eop[i]           = qb[i][0].e;
      end
    end
  endtask

  // Negedge: score writes against the beats popped one cycle earlier, log new pops
  task automatic sample();
    beat_t e;
    cyc++;
    if (pend_a) begin
      chk("a_write", 64'(a_write), 64'd1);
      if (expa.size() > 0) begin
        e = expa.pop_front();
        chk("a_data", 64'(a_wdata), e.d);
        chk("a_tag", 64'(a_wtag), 64'(e.t));
        chk("a_eop", 64'(a_weop), 64'(e.e));
        chk("a_chan", 64'(a_wchan), 64'(e.ch));
      end
    end else begin
      chk("a_write_idle", 64'(a_write), 64'd0);
    end
    chk("a_rd_onehot", 64'($onehot0(a_rd)), 64'd1);
    chk("a_rd_empty", 64'(a_rd & a_empty), 64'd0);
    s_rd_a = a_rd; s_wa = a_write; s_lock_a = a_locked;
    s_wdata_a = a_wdata; s_wchan_a = a_wchan;
    for (int i = 0; i < 4; i++) begin
      if (a_rd[i] && qa[i].size() > 0) begin
        e = qa[i][0];
        e.ch = 4'(i);
        expa.push_back(e);
        pop_ch.push_back(i);
        pop_cyc.push_back(cyc);
      end
    end
    pend_a = (a_rd != 4'd0) && !reset;
    if (a_write) wr_cnt++;

    if (pend_b) begin
      chk("b_write", 64'(b_write), 64'd1);
      if (expb.size() > 0) begin
        e = expb.pop_front();
        chk("b_data", b_wdata, e.d);
        chk("b_tag", 64'(b_wtag), 64'(e.t[7:0]));
        chk("b_eop", 64'(b_weop), 64'(e.e));
        chk("b_chan", 64'(b_wchan), 64'(e.ch));
      end
    end else begin
      chk("b_write_idle", 64'(b_write), 64'd0);
    end
    chk("b_rd_onehot", 64'($onehot0(b_rd)), 64'd1);
    s_rd_b = b_rd;
    for (int i = 0; i < 2; i++) begin
      if (b_rd[i] && qb[i].size() > 0) begin
        e = qb[i][0];
        e.ch = 4'(i);
        expb.push_back(e);
        popb_ch.push_back(i);
      end
    end
    pend_b = (b_rd != 2'd0) && !reset;
  endtask

  // After the edge: retire popped heads and advance the downstream occupancy model
  task automatic update();
    for (int i = 0; i < 4; i++)
      if (s_rd_a[i] && qa[i].size() > 0) qa[i].delete(0);
    for (int i = 0; i < 2; i++)
      if (s_rd_b[i] && qb[i].size() > 0) qb[i].delete(0);
    if (s_wa) occ++;
    if (drain_en && occ > 0) occ--;
  endtask

  task automatic step();
    drive();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    update();
  endtask

  task automatic push_a(input int ch, input logic [31:0] d, input logic [15:0] t, input logic e);
    beat_t b;
    b.d = 64'(d); b.t = t; b.e = e; b.ch = 4'(ch);
    qa[ch].push_back(b);
  endtask

  task automatic push_b(input int ch, input logic [63:0] d, input logic [7:0] t, input logic e);
    beat_t b;
    b.d = d; b.t = 16'(t); b.e = e; b.ch = 4'(ch);
    qb[ch].push_back(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) qa[i].delete();
    for (int i = 0; i < 2; i++) qb[i].delete();
    step();
    step();
    occ = 0; force_full = 1'b0; drain_en = 1'b0;
    pop_ch.delete(); pop_cyc.delete(); popb_ch.delete(); wr_cnt = 0;
    reset = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int lim);
    for (int k = 0; k < lim && pop_ch.size() < n; k++) step();
    chk("wait_pops", 64'(pop_ch.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 5'd0,  4'b0001, 4'b0001};
    vt[1] = '{1'b0, 5'd0,  4'b1110, 4'b0010};
    vt[2] = '{1'b0, 5'd0,  4'b1000, 4'b1000};
    vt[3] = '{1'b0, 5'd15, 4'b1111, 4'b0001};
    vt[4] = '{1'b0, 5'd16, 4'b1111, 4'b0000};
    vt[5] = '{1'b1, 5'd0,  4'b1111, 4'b0000};
    vt[6] = '{1'b0, 5'd0,  4'b0000, 4'b0000};
    vt[7] = '{1'b0, 5'd14, 4'b1100, 4'b0100};

    // Reset state
    step();
    step();
    chk("rst_write", 64'(s_wa), 64'd0);
    chk("rst_locked", 64'(s_lock_a), 64'd0);
    chk("rst_rd", 64'(s_rd_a), 64'd0);
    chk("rst_data", 64'(s_wdata_a), 64'd0);
    chk("rst_chan", 64'(s_wchan_a), 64'd0);
    reset = 1'b0;

    // Priority from reset pointer and credit boundaries, one vector per fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      occ = int'(vt[i].fc);
      force_full = vt[i].full;
      for (int c = 0; c < 4; c++)
        if (vt[i].mask[c]) push_a(c, 32'h100 + 32'(c), 16'h0F00 + 16'(c), 1'b1);
      step();
      chk($sformatf("vec%0d_rd", i), 64'(s_rd_a), 64'(vt[i].exp_rd));
    end

    // Single channel, 3-beat packet
    do_reset();
    push_a(0, 32'hA0, 16'h0011, 1'b0);
    push_a(0, 32'hA1, 16'h0011, 1'b0);
    push_a(0, 32'hA2, 16'h0011, 1'b1);
    wait_pops(3, 10);
    step();
    step();
    chk("single_wr_cnt", 64'(wr_cnt), 64'd3);
    for (int k = 0; k < pop_ch.size(); k++) begin
      chk("single_ch", 64'(pop_ch[k]), 64'd0);
      chk("single_cyc", 64'(pop_cyc[k] - pop_cyc[0]), 64'(k));
    end

    // Round-robin fairness with single-beat packets
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) push_a(c, 32'hB0 + 32'(c * 16 + k), 16'h0B00 + 16'(c), 1'b1);
    wait_pops(8, 20);
    for (int k = 0; k < pop_ch.size(); k++) begin
      chk("rr_order", 64'(pop_ch[k]), 64'(k % 4));
      chk("rr_cyc", 64'(pop_cyc[k] - pop_cyc[0]), 64'(k));
    end

    // Packet lock holds across an empty gap on the locked channel
    do_reset();
    push_a(1, 32'hC0, 16'h0101, 1'b0);
    push_a(1, 32'hC1, 16'h0101, 1'b0);
    push_a(2, 32'hD0, 16'h0202, 1'b1);
    wait_pops(2, 10);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("gap_rd", 64'(s_rd_a), 64'd0);
      chk("gap_locked", 64'(s_lock_a), 64'd1);
    end
    push_a(1, 32'hC2, 16'h0101, 1'b0);
    push_a(1, 32'hC3, 16'h0101, 1'b1);
    wait_pops(5, 12);
    if (pop_ch.size() == 5) begin
      chk("lock_o2", 64'(pop_ch[2]), 64'd1);
      chk("lock_o3", 64'(pop_ch[3]), 64'd1);
      chk("lock_o4", 64'(pop_ch[4]), 64'd2);
      chk("lock_gap_len", 64'(pop_cyc[2] - pop_cyc[1]), 64'd3);
    end
    step();
    step();
    chk("lock_released", 64'(s_lock_a), 64'd0);

    // Credit: one slot left, then stall until the downstream drains
    do_reset();
    occ = 15;
    for (int k = 0; k < 4; k++) push_a(0, 32'hE0 + 32'(k), 16'h0E0E, 1'b1);
    for (int k = 0; k < 6; k++) step();
    chk("credit_pops", 64'(pop_ch.size()), 64'd1);
    chk("credit_writes", 64'(wr_cnt), 64'd1);
    drain_en = 1'b1;
    wait_pops(4, 30);

    // Downstream full flag blocks every pop
    do_reset();
    force_full = 1'b1;
    for (int c = 0; c < 4; c++) push_a(c, 32'hF0 + 32'(c), 16'h0F0F, 1'b1);
    for (int k = 0; k < 4; k++) step();
    chk("full_pops", 64'(pop_ch.size()), 64'd0);

    // Reset while locked on channel 3 with a write pending
    do_reset();
    push_a(3, 32'h30, 16'h0303, 1'b0);
    push_a(3, 32'h31, 16'h0303, 1'b0);
    push_a(3, 32'h32, 16'h0303, 1'b1);
    wait_pops(1, 10);
    reset = 1'b1;
    push_a(0, 32'h50, 16'h0505, 1'b1);
    step();
    chk("rstmid_rd_held", 64'(s_rd_a), 64'd0);
    step();
    chk("rstmid_write", 64'(s_wa), 64'd0);
    chk("rstmid_locked", 64'(s_lock_a), 64'd0);
    chk("rstmid_rd", 64'(s_rd_a), 64'd0);
    chk("rstmid_data", 64'(s_wdata_a), 64'd0);
    reset = 1'b0;
    wait_pops(4, 12);
    if (pop_ch.size() == 4) begin
      chk("rstmid_first", 64'(pop_ch[1]), 64'd0);
      chk("rstmid_then3", 64'(pop_ch[2]), 64'd3);
    end

    // Two-channel wide instance: alternating stream
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_b(0, 64'hCAFE_0000_0000_0000 + 64'(k), 8'h10 + 8'(k), 1'b1);
      push_b(1, 64'h0000_BEEF_0000_0100 + 64'(k), 8'h20 + 8'(k), 1'b1);
    end
    for (int k = 0; k < 20 && popb_ch.size() < 6; k++) step();
    chk("b_pops", 64'(popb_ch.size()), 64'd6);
    for (int k = 0; k < popb_ch.size(); k++) chk("b_order", 64'(popb_ch[k]), 64'(k % 2));

    step();
    step();
    chk("a_sb_empty", 64'(expa.size()), 64'd0);
    chk("b_sb_empty", 64'(expb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
